wb_rr_scheduler: RTL and testbench
==================================

Name: wb_rr_scheduler

Overview:
- Shares a single write-back channel among NUM_SRC producers (execution units) using round-robin fairness.
- Each producer presents a valid/ready channel with a payload; one winner per cycle is captured into a registered output stage.
- The output stage drives the write-back bus with a valid/ready handshake.
- Sits between the functional units and the register-file write port; flush support covers pipeline squash.

Parameters:
- NUM_SRC, 4, number of producers (2..16).
- DATA_WIDTH, 64, payload width per producer.
- SRC_W, $clog2(NUM_SRC), source-index width (localparam, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- arst_ni  input  1  asynchronous reset, active-low.
- flush_i  input  1  synchronous squash of the output stage.
- src_valid_i  input  NUM_SRC  per-producer valid.
- src_data_i  input  NUM_SRC*DATA_WIDTH  packed payloads; producer k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_ready_o  output  NUM_SRC  per-producer accept; at most one bit high per cycle.
- wb_valid_o  output  1  output stage holds a valid beat.
- wb_data_o  output  DATA_WIDTH  registered payload.
- wb_src_o  output  SRC_W  index of the producer that supplied wb_data_o.
- wb_ready_i  input  1  consumer accepts the beat.
- busy_o  output  1  high when wb_valid_o is high or any src_valid_i bit is high.

Behaviour:
- Reset (arst_ni low, asynchronous):
  - wb_valid_o=0, wb_data_o=0, wb_src_o=0, pointer ptr=0.
  - src_ready_o=0 while in reset.
- Stage free condition: load_en = ~wb_valid_o | wb_ready_i, evaluated combinationally, and only when flush_i=0.
- Selection (combinational):
  - Search src_valid_i starting at index ptr, ascending with wrap to 0.
  - The first set bit is the winner g.
  - If no bit is set, there is no winner.
- Grant:
  - When load_en=1 and a winner exists, src_ready_o[g]=1 and all other bits are 0.
  - Otherwise src_ready_o=0.
  - src_ready_o may depend combinationally on src_valid_i and wb_ready_i; producers must not make src_valid_i depend on src_ready_o.
- Transfer on a clock edge with src_valid_i[g] & src_ready_o[g]:
  - wb_data_o <= payload g.
  - wb_src_o <= g.
  - wb_valid_o <= 1.
  - ptr <= (g+1) mod NUM_SRC. When g=NUM_SRC-1, ptr wraps to 0.
- Drain:
  - wb_valid_o & wb_ready_i with no new winner gives wb_valid_o <= 0.
  - wb_data_o and wb_src_o hold their last value.
- Simultaneous drain and load: the beat is replaced in the same cycle. This gives full throughput of one beat per cycle and no bubble.
- Hold:
  - While wb_valid_o=1 and wb_ready_i=0, wb_data_o and wb_src_o are stable and src_ready_o=0.
  - ptr is unchanged.
- Flush (flush_i=1 at an edge):
  - wb_valid_o <= 0.
  - No producer is accepted that cycle (src_ready_o=0).
  - ptr is unchanged.
  - Flush takes priority over load and drain.
- Latency: one cycle from an accepted src beat to wb_valid_o.
- Fairness: a continuously asserting producer waits at most NUM_SRC-1 transfers before it is granted.
- Pointer update: ptr advances only on a transfer, never on idle cycles.
- Reset mid-operation: any beat in the output stage is discarded and ptr returns to 0.
- busy_o is combinational.

Decomposition:
- Shared package wb_sched_pkg holds the default NUM_SRC and DATA_WIDTH constants and a typedef for the source index (logic [SRC_W-1:0]).
- One sub-module, rr_priority_select (combinational):
  - Inputs: valid vector, start pointer.
  - Outputs: one-hot grant, binary index, any_valid.
  - Implementation: double-width masked priority search.
- The top level contains only the handshake logic, the output register and the pointer register.

Test Plan:
- Reset, then single producer: src_valid_i=4'b0100 with data 0xA5, wb_ready_i=1 -> src_ready_o=4'b0100 in the same cycle; next cycle wb_valid_o=1, wb_data_o=0xA5, wb_src_o=2, ptr=3.
- All producers valid continuously, wb_ready_i=1, from reset -> wb_src_o sequence is 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: wb_ready_i=0 for 3 cycles with a beat held from source 1 -> wb_data_o and wb_src_o stable, src_ready_o=0, ptr stays 2; on release, the next grant goes to the lowest valid index at or after 2.
- Wrap fairness: ptr=3, src_valid_i=4'b1001 -> grant source 3, then source 0, then source 3 on successive transfers.
- Flush while wb_valid_o=1 and src_valid_i=4'b0010 -> next cycle wb_valid_o=0, no acceptance in the flush cycle, ptr unchanged; source 1 is accepted the following cycle.
- Async reset asserted mid-stream with wb_valid_o=1 -> wb_valid_o=0, src_ready_o=0 and ptr=0 immediately; after release, the first grant goes to the lowest-index valid producer.

Source files
------------

// File: rtl/wb_sched_pkg.sv
// rtl/wb_sched_pkg.sv - shared defaults and types for the write-back round-robin scheduler
package wb_sched_pkg;

  localparam int unsigned WB_NUM_SRC    = 4;
  localparam int unsigned WB_DATA_WIDTH = 64;
  localparam int unsigned WB_SRC_W      = $clog2(WB_NUM_SRC);

  typedef logic [WB_SRC_W-1:0] wb_src_idx_t;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - round-robin priority search starting at a pointer, with wrap
module rr_priority_select
  import wb_sched_pkg::*;
#(
  parameter int unsigned N = WB_NUM_SRC,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_valid_o
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;

  // Upper half covers the wrapped search, lower half only indices at or after ptr_i.
  always_comb begin
    mask  = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    dbl = {valid_i, valid_i & mask};
    for (int i = 0; i < 2 * int'(N); i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx_o = W'(i % int'(N));
      end
    end
  end

  assign any_valid_o = |valid_i;
  assign grant_o     = any_valid_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/wb_rr_scheduler.sv
// rtl/wb_rr_scheduler.sv - round-robin arbiter of producers onto one registered write-back channel
module wb_rr_scheduler
  import wb_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC    = WB_NUM_SRC,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  localparam int unsigned SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic                          flush_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  output logic                          wb_valid_o,
  output logic [DATA_WIDTH-1:0]         wb_data_o,
  output logic [SRC_W-1:0]              wb_src_o,
  input  logic                          wb_ready_i,
  output logic                          busy_o
);

  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [SRC_W-1:0]      wb_src_q, wb_src_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   win_idx;
  logic               any_valid;
  logic               load_en;
  logic               transfer;

  rr_priority_select #(
    .N (NUM_SRC)
  ) u_select (
    .valid_i     (src_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .idx_o       (win_idx),
    .any_valid_o (any_valid)
  );

  // arst_ni gating keeps src_ready_o low for the whole time reset is held.
  assign load_en     = (~wb_valid_q | wb_ready_i) & ~flush_i & arst_ni;
  assign transfer    = load_en & any_valid;
  assign src_ready_o = load_en ? grant : '0;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;
    ptr_d      = ptr_q;
    if (flush_i) begin
      wb_valid_d = 1'b0;
    end else if (transfer) begin
      wb_valid_d = 1'b1;
      wb_data_d  = src_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
      wb_src_d   = win_idx;
      ptr_d      = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + SRC_W'(1);
    end else if (wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
      ptr_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
      ptr_q      <= ptr_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_src_o   = wb_src_q;
  assign busy_o     = wb_valid_q | (|src_valid_i);

endmodule

// File: tb/tb_wb_rr_scheduler.sv
// tb/tb_wb_rr_scheduler.sv - directed self-checking bench for wb_rr_scheduler
module tb_wb_rr_scheduler;

  localparam int NS = 4;
  localparam int DW = 64;

  logic             clk_i = 1'b0;
  logic             arst_ni;
  logic             flush_i;
  logic [NS-1:0]    src_valid_i;
  logic [NS*DW-1:0] src_data_i;
  logic [NS-1:0]    src_ready_o;
  logic             wb_valid_o;
  logic [DW-1:0]    wb_data_o;
  logic [1:0]       wb_src_o;
  logic             wb_ready_i;
  logic             busy_o;

  int errors = 0;
  int checks = 0;

  wb_rr_scheduler dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .flush_i     (flush_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .wb_valid_o  (wb_valid_o),
    .wb_data_o   (wb_data_o),
    .wb_src_o    (wb_src_o),
    .wb_ready_i  (wb_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_default_data();
    for (int k = 0; k < NS; k++) src_data_i[k*DW +: DW] = 64'h100 + 64'(k);
  endtask

  initial begin
    arst_ni     = 1'b0;
    flush_i     = 1'b0;
    src_valid_i = '0;
    src_data_i  = '0;
    wb_ready_i  = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_data", wb_data_o, 64'd0);
    chk("rst_src", 64'(wb_src_o), 64'd0);
    chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
    src_valid_i = 4'b1111;
    wb_ready_i  = 1'b1;
    #1;
    chk("rst_ready_gated", 64'(src_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd1);
    src_valid_i = '0;
    @(negedge clk_i);
    arst_ni = 1'b1;
    cyc();

    // single producer 2
    load_default_data();
    src_data_i[2*DW +: DW] = 64'hA5;
    src_valid_i = 4'b0100;
    #1;
    chk("t1_ready", 64'(src_ready_o), 64'b0100);
    cyc();
    chk("t1_valid", 64'(wb_valid_o), 64'd1);
    chk("t1_data", wb_data_o, 64'hA5);
    chk("t1_src", 64'(wb_src_o), 64'd2);
    chk("t1_ptr", 64'(dut.ptr_q), 64'd3);
    src_valid_i = '0;
    #1;
    chk("t1_idle_ready", 64'(src_ready_o), 64'd0);
    cyc();
    chk("t1_drain_valid", 64'(wb_valid_o), 64'd0);
    chk("t1_drain_data", wb_data_o, 64'hA5);
    chk("t1_drain_ptr", 64'(dut.ptr_q), 64'd3);
    chk("t1_busy", 64'(busy_o), 64'd0);

    // reset back to ptr 0, then all producers streaming
    arst_ni = 1'b0;
    #1;
    chk("t2_rst_ptr", 64'(dut.ptr_q), 64'd0);
    arst_ni = 1'b1;
    load_default_data();
    src_valid_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_ready", 64'(src_ready_o), 64'(4'b0001 << (i % 4)));
      cyc();
      chk("t2_valid", 64'(wb_valid_o), 64'd1);
      chk("t2_src", 64'(wb_src_o), 64'(i % 4));
      chk("t2_data", wb_data_o, 64'h100 + 64'(i % 4));
    end
    chk("t2_ptr", 64'(dut.ptr_q), 64'd2);

    // backpressure holding the beat from source 1
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_ready_hold", 64'(src_ready_o), 64'd0);
      cyc();
      chk("t3_valid", 64'(wb_valid_o), 64'd1);
      chk("t3_src", 64'(wb_src_o), 64'd1);
      chk("t3_data", wb_data_o, 64'h101);
      chk("t3_ptr", 64'(dut.ptr_q), 64'd2);
    end
    wb_ready_i  = 1'b1;
    src_valid_i = 4'b1011;
    #1;
    chk("t3_release_ready", 64'(src_ready_o), 64'b1000);
    cyc();
    chk("t3_release_src", 64'(wb_src_o), 64'd3);
    chk("t3_release_ptr", 64'(dut.ptr_q), 64'd0);

    // wrap fairness from ptr 3
    src_valid_i = 4'b0100;
    cyc();
    chk("t4_ptr3", 64'(dut.ptr_q), 64'd3);
    src_valid_i = 4'b1001;
    #1;
    chk("t4_ready_a", 64'(src_ready_o), 64'b1000);
    cyc();
    chk("t4_src_a", 64'(wb_src_o), 64'd3);
    #1;
    chk("t4_ready_b", 64'(src_ready_o), 64'b0001);
    cyc();
    chk("t4_src_b", 64'(wb_src_o), 64'd0);
    #1;
    chk("t4_ready_c", 64'(src_ready_o), 64'b1000);
    cyc();
    chk("t4_src_c", 64'(wb_src_o), 64'd3);
    chk("t4_ptr_c", 64'(dut.ptr_q), 64'd0);
    src_valid_i = 4'b0001;
    cyc();
    chk("t4_ptr_d", 64'(dut.ptr_q), 64'd1);

    // flush with source 1 waiting
    src_valid_i = 4'b0010;
    flush_i     = 1'b1;
    #1;
    chk("t5_flush_ready", 64'(src_ready_o), 64'd0);
    cyc();
    chk("t5_flush_valid", 64'(wb_valid_o), 64'd0);
    chk("t5_flush_ptr", 64'(dut.ptr_q), 64'd1);
    chk("t5_flush_src", 64'(wb_src_o), 64'd0);
    flush_i = 1'b0;
    #1;
    chk("t5_after_ready", 64'(src_ready_o), 64'b0010);
    cyc();
    chk("t5_after_valid", 64'(wb_valid_o), 64'd1);
    chk("t5_after_src", 64'(wb_src_o), 64'd1);
    chk("t5_after_data", wb_data_o, 64'h101);
    chk("t5_after_ptr", 64'(dut.ptr_q), 64'd2);

    // async reset mid-stream
    src_valid_i = 4'b1111;
    #1;
    arst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(wb_valid_o), 64'd0);
    chk("t6_rst_ready", 64'(src_ready_o), 64'd0);
    chk("t6_rst_ptr", 64'(dut.ptr_q), 64'd0);
    chk("t6_rst_data", wb_data_o, 64'd0);
    @(negedge clk_i);
    arst_ni     = 1'b1;
    src_valid_i = 4'b0110;
    #1;
    chk("t6_ready", 64'(src_ready_o), 64'b0010);
    cyc();
    chk("t6_src", 64'(wb_src_o), 64'd1);
    chk("t6_valid", 64'(wb_valid_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
